// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory controller slice.
// Holds the processor/memory interface types (address, block, tag, command),
// the owner tag used to route load responses, the controller FSM state codes,
// the outstanding-load table entry and the latched (rejected) request record.
package dmem_ctrl_pkg;

  localparam int ADDR_W       = 32;
  localparam int BLOCK_W      = 64;
  localparam int TAG_W        = 4;
  localparam int NUM_MEM_TAGS = 15;

  typedef logic [ADDR_W-1:0]  ADDR;
  typedef logic [BLOCK_W-1:0] MEM_BLOCK;
  typedef logic [TAG_W-1:0]   MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic {
    OWN_LSU = 1'b0,
    OWN_IC  = 1'b1
  } DMEM_OWNER;

  // Controller FSM state codes
  localparam logic [0:0] DC_IDLE = 1'b0;
  localparam logic [0:0] DC_PEND = 1'b1;

  typedef struct packed {
    logic      valid;
    DMEM_OWNER owner;
    ADDR       addr;
  } DMEM_TAG_ENTRY;

  // A store or load that memory rejected and that is being retried.
  // Icache requests are never latched, so no owner is needed here.
  typedef struct packed {
    MEM_COMMAND cmd;
    ADDR        addr;
    MEM_BLOCK   data;
  } DMEM_PEND_REQ;

  // Memory works on 8-byte blocks; the low three address bits are dropped.
  function automatic ADDR align_addr(input ADDR a);
    return a & ~ADDR'(7);
  endfunction

endpackage

// File: rtl/dmem_tag_table.sv
// Outstanding-load table indexed by memory tag.
// One entry per tag (tag 0 is never allocated). An accepted load allocates
// its tag with owner and aligned address; a returning response frees it.
// Ports:
//   clock, reset        clock and synchronous active-high reset (clears all entries)
//   alloc_en_i/tag/entry write a new entry for an accepted load
//   free_en_i/free_tag_i invalidate the entry whose data has returned
//   rd_tag_i/rd_entry_o  combinational lookup for the returning data tag
module dmem_tag_table
  import dmem_ctrl_pkg::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          alloc_en_i,
  input  MEM_TAG        alloc_tag_i,
  input  DMEM_TAG_ENTRY alloc_entry_i,
  input  logic          free_en_i,
  input  MEM_TAG        free_tag_i,
  input  MEM_TAG        rd_tag_i,
  output DMEM_TAG_ENTRY rd_entry_o
);

  DMEM_TAG_ENTRY table_q [NUM_TAGS+1];

  assign rd_entry_o = table_q[rd_tag_i];

  // Free is written before allocation so that a tag returned and reissued
  // in the same cycle keeps the newly allocated entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= NUM_TAGS; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      if (free_en_i) begin
        table_q[free_tag_i].valid <= 1'b0;
      end
      if (alloc_en_i) begin
        table_q[alloc_tag_i] <= alloc_entry_i;
      end
    end
  end

  // Memory must never reissue a tag that is still in use.
  always_ff @(posedge clock) begin
    if (!reset && alloc_en_i) begin
      assert (!table_q[alloc_tag_i].valid || (free_en_i && (free_tag_i == alloc_tag_i)));
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: owns the single processor-to-memory port.
// Arbitrates store commit > load FU > icache miss, drives the winner in the
// same cycle, latches a rejected store/load and retries it until accepted
// (dm_stalled high meanwhile), records accepted loads by tag and routes the
// tagged responses back to the load FU or the icache.
// Ports:
//   clock, reset                      clock, synchronous active-high reset
//   start_store/store_addr/store_data store commit request
//   start_load/Dmem_addr              load FU request
//   ic_req/ic_addr, ic_gnt            icache miss request and its acceptance
//   mem2proc_*                        memory tag for this command, returning tag/data
//   proc2mem_*                        command, aligned address and store data to memory
//   dm_stalled                        a rejected request is being retried
//   Dmem_data_ready/base_addr/load_data  load response to the load FU
//   ic_data_ready/ic_data_addr/ic_data   fill response to the icache
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_store,
  input  logic [ADDR_W-1:0]   store_addr,
  input  logic [BLOCK_W-1:0]  store_data,
  input  logic                start_load,
  input  logic [ADDR_W-1:0]   Dmem_addr,
  input  logic                ic_req,
  input  logic [ADDR_W-1:0]   ic_addr,
  input  logic [TAG_W-1:0]    mem2proc_transaction_tag,
  input  logic [TAG_W-1:0]    mem2proc_data_tag,
  input  logic [BLOCK_W-1:0]  mem2proc_data,
  output logic [1:0]          proc2mem_command,
  output logic [ADDR_W-1:0]   proc2mem_addr,
  output logic [BLOCK_W-1:0]  proc2mem_data,
  output logic                dm_stalled,
  output logic                ic_gnt,
  output logic                Dmem_data_ready,
  output logic [ADDR_W-1:0]   Dmem_base_addr,
  output logic [BLOCK_W-1:0]  Dmem_load_data,
  output logic                ic_data_ready,
  output logic [ADDR_W-1:0]   ic_data_addr,
  output logic [BLOCK_W-1:0]  ic_data
);

  logic [0:0]    state_q, state_d;
  DMEM_PEND_REQ  pend_q, pend_d;

  MEM_COMMAND    cmd;
  ADDR           cmd_addr;
  MEM_BLOCK      cmd_data;
  DMEM_OWNER     cmd_owner;
  logic          accepted;
  logic          ic_win;

  logic          alloc_en;
  DMEM_TAG_ENTRY alloc_entry;
  DMEM_TAG_ENTRY rd_entry;
  logic          hit;

  assign accepted = (mem2proc_transaction_tag != '0);

  // Port arbitration: a latched request owns the port until memory takes it;
  // otherwise store beats load beats icache. Only store/load rejections are
  // latched; a rejected icache request simply reappears next cycle.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cmd       = MEM_NONE;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_owner = OWN_LSU;
    ic_win    = 1'b0;
    case (state_q)
      DC_IDLE: begin
        if (start_store) begin
          cmd      = MEM_STORE;
          cmd_addr = align_addr(store_addr);
          cmd_data = store_data;
        end else if (start_load) begin
          cmd      = MEM_LOAD;
          cmd_addr = align_addr(Dmem_addr);
        end else if (ic_req) begin
          cmd       = MEM_LOAD;
          cmd_addr  = align_addr(ic_addr);
          cmd_owner = OWN_IC;
          ic_win    = 1'b1;
        end
        if ((start_store || start_load) && !accepted) begin
          pend_d  = '{cmd: cmd, addr: cmd_addr, data: cmd_data};
          state_d = DC_PEND;
        end
      end
      DC_PEND: begin
        cmd      = pend_q.cmd;
        cmd_addr = pend_q.addr;
        cmd_data = (pend_q.cmd == MEM_STORE) ? pend_q.data : '0;
        if (accepted) begin
          state_d = DC_IDLE;
        end
      end
      default: state_d = DC_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DC_IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign alloc_en    = !reset && (cmd == MEM_LOAD) && accepted;
  assign alloc_entry = '{valid: 1'b1, owner: cmd_owner, addr: cmd_addr};
  assign hit         = !reset && (mem2proc_data_tag != '0) && rd_entry.valid;

  dmem_tag_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_tag_table (
    .clock         (clock),
    .reset         (reset),
    .alloc_en_i    (alloc_en),
    .alloc_tag_i   (mem2proc_transaction_tag),
    .alloc_entry_i (alloc_entry),
    .free_en_i     (hit),
    .free_tag_i    (mem2proc_data_tag),
    .rd_tag_i      (mem2proc_data_tag),
    .rd_entry_o    (rd_entry)
  );

  // Outputs are forced quiet while reset is asserted.
  assign proc2mem_command = reset ? MEM_NONE : cmd;
  assign proc2mem_addr    = reset ? '0 : cmd_addr;
  assign proc2mem_data    = (reset || (cmd != MEM_STORE)) ? '0 : cmd_data;
  assign dm_stalled       = !reset && (state_q == DC_PEND);
  assign ic_gnt           = !reset && ic_win && accepted;

  assign Dmem_data_ready  = hit && (rd_entry.owner == OWN_LSU);
  assign Dmem_base_addr   = Dmem_data_ready ? rd_entry.addr : '0;
  assign Dmem_load_data   = Dmem_data_ready ? mem2proc_data : '0;
  assign ic_data_ready    = hit && (rd_entry.owner == OWN_IC);
  assign ic_data_addr     = ic_data_ready ? rd_entry.addr : '0;
  assign ic_data          = ic_data_ready ? mem2proc_data : '0;

endmodule
